can_rx_mailbox: RTL

Parametrised receive mailbox for the CAN controller. It replaces the single-frame receive register, which can only flag an overwrite, with a DEPTH-entry FIFO. Ahead of the FIFO sits a bank of NFILT ID/mask acceptance filters. It takes completed, CRC-good frames from the CAN receiver and exposes the head frame, status and filter configuration on the 32-bit peripheral register bus, with a level-threshold and overflow interrupt.

---
 rtl/can_pkg.sv | 37 +++
 rtl/can_acc_filter.sv | 52 +++++
 rtl/can_rx_mailbox.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types and register-map constants for the CAN receive mailbox.
package can_pkg;

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_frame_t;

  localparam logic [2:0] REG_HEAD_ID    = 3'd0;
  localparam logic [2:0] REG_HEAD_DLC   = 3'd1;
  localparam logic [2:0] REG_HEAD_DATA0 = 3'd2;
  localparam logic [2:0] REG_HEAD_DATA1 = 3'd3;
  localparam logic [2:0] REG_CTRL       = 3'd4;
  localparam logic [2:0] REG_FSEL       = 3'd5;
  localparam logic [2:0] REG_FID        = 3'd6;
  localparam logic [2:0] REG_FMASK      = 3'd7;

  localparam int CTRL_POP     = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;
  localparam int CTRL_CLR_REJ = 3;
  localparam int CTRL_EMPTY   = 5;
  localparam int CTRL_FULL    = 6;
  localparam int CTRL_OVF     = 7;
  localparam int CTRL_IRQEN   = 8;
  localparam int CTRL_THRESH  = 16;
  localparam int CTRL_REJCNT  = 24;

  function automatic logic id_match(input logic [28:0] a, input logic [28:0] b,
                                    input logic [28:0] mask);
    return ((a ^ b) & mask) == 29'd0;
  endfunction

endpackage

// File: rtl/can_acc_filter.sv
// One ID/mask acceptance filter; hit is evaluated against the value being
// written this cycle so a reconfiguration applies to the frame in stage 1.
module can_acc_filter
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_id,
  input  logic        wr_mask,
  input  logic        wr_en,
  input  logic        wr_ext,
  input  logic [28:0] wr_val,
  input  logic        frm_ext,
  input  logic [28:0] frm_id,
  output logic        act_en,
  output logic        hit,
  output logic [31:0] fid_rd,
  output logic [31:0] fmask_rd
);

  logic        en_q, en_d, ext_q, ext_d;
  logic [28:0] id_q, id_d, mask_q, mask_d;

  // Next filter configuration and match against it
  always_comb begin
    en_d   = wr_id ? wr_en : en_q;
    ext_d  = wr_id ? wr_ext : ext_q;
    id_d   = wr_id ? wr_val : id_q;
    mask_d = wr_mask ? wr_val : mask_q;
    act_en = en_d;
    hit    = en_d & (ext_d == frm_ext) & id_match(frm_id, id_d, mask_d);
  end

  // Filter configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      ext_q  <= 1'b0;
      id_q   <= 29'd0;
      mask_q <= 29'd0;
    end else begin
      en_q   <= en_d;
      ext_q  <= ext_d;
      id_q   <= id_d;
      mask_q <= mask_d;
    end
  end

  assign fid_rd   = {en_q, ext_q, 1'b0, id_q};
  assign fmask_rd = {3'b000, mask_q};

endmodule

// File: rtl/can_rx_mailbox.sv
// Receive mailbox: one-stage filter pipeline feeding a DEPTH-entry frame FIFO,
// with head/status/filter access on the register bus and a level interrupt.
module can_rx_mailbox
  import can_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFILT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frm_valid,
  input  logic        frm_ext,
  input  logic        frm_rtr,
  input  logic [28:0] frm_id,
  input  logic [3:0]  frm_dlc,
  input  logic [63:0] frm_data,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic             s1_vld_q, s1_vld_d;
  can_frame_t       s1_frm_q, s1_frm_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       rej_q, rej_d;
  logic [1:0]       irqen_q, irqen_d;
  logic [4:0]       thresh_q, thresh_d;
  logic [2:0]       fsel_q, fsel_d;
  can_frame_t       mem_q [DEPTH];

  logic [NFILT-1:0] f_en, f_hit;
  logic [31:0]      f_id_rd [NFILT];
  logic [31:0]      f_mask_rd [NFILT];

  logic wr_ctrl_s, pop_s, flush_s, clr_ovf_s, clr_rej_s, full_s, empty_s;
  logic accept_s, reject_s, push_s, ovf_evt_s;
  logic unused_s;

  assign unused_s = d[29];

  for (genvar i = 0; i < NFILT; i++) begin : g_filt
    can_acc_filter u_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_id    (cs & we & (rs == REG_FID) & (fsel_q == 3'(i))),
      .wr_mask  (cs & we & (rs == REG_FMASK) & (fsel_q == 3'(i))),
      .wr_en    (d[31]),
      .wr_ext   (d[30]),
      .wr_val   (d[28:0]),
      .frm_ext  (s1_frm_q.ext),
      .frm_id   (s1_frm_q.id),
      .act_en   (f_en[i]),
      .hit      (f_hit[i]),
      .fid_rd   (f_id_rd[i]),
      .fmask_rd (f_mask_rd[i])
    );
  end

  assign wr_ctrl_s = cs & we & (rs == REG_CTRL);
  assign empty_s   = (level_q == {LW{1'b0}});
  assign full_s    = (level_q == LW'(DEPTH));
  assign pop_s     = wr_ctrl_s & d[CTRL_POP] & ~empty_s;
  assign flush_s   = wr_ctrl_s & d[CTRL_FLUSH];
  assign clr_ovf_s = wr_ctrl_s & d[CTRL_CLR_OVF];
  assign clr_rej_s = wr_ctrl_s & d[CTRL_CLR_REJ];
  // A flush discards the stage-1 frame outright: no push, reject count or overflow.
  assign accept_s  = s1_vld_q & ~flush_s & ((f_en == {NFILT{1'b0}}) | (|f_hit));
  assign reject_s  = s1_vld_q & ~flush_s & (f_en != {NFILT{1'b0}}) & ~(|f_hit);
  assign push_s    = accept_s & (~full_s | pop_s);
  assign ovf_evt_s = accept_s & full_s & ~pop_s;

  // Next-state for pipeline, pointers, status and control registers
  always_comb begin
    s1_vld_d = frm_valid;
    s1_frm_d = frm_valid ? can_frame_t'{frm_ext, frm_rtr, frm_id, frm_dlc, frm_data} : s1_frm_q;
    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    if (ovf_evt_s)      ovf_d = 1'b1;
    else if (clr_ovf_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
    if (clr_rej_s)                        rej_d = 8'd0;
    else if (reject_s && rej_q != 8'hFF)  rej_d = rej_q + 8'd1;
    else                                  rej_d = rej_q;
    irqen_d  = wr_ctrl_s ? d[CTRL_IRQEN +: 2] : irqen_q;
    thresh_d = wr_ctrl_s ? d[CTRL_THRESH +: 5] : thresh_q;
    fsel_d   = (cs & we & (rs == REG_FSEL)) ? d[2:0] : fsel_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_frm_q <= '0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      ovf_q    <= 1'b0;
      rej_q    <= 8'd0;
      irqen_q  <= 2'b00;
      thresh_q <= 5'd1;
      fsel_q   <= 3'd0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_frm_q <= s1_frm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      rej_q    <= rej_d;
      irqen_q  <= irqen_d;
      thresh_q <= thresh_d;
      fsel_q   <= fsel_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s1_frm_q;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Register read mux
  always_comb begin
    can_frame_t  head;
    logic [31:0] fid_sel, fmask_sel;
    head      = empty_s ? '0 : mem_q[rd_ptr_q];
    fid_sel   = 32'd0;
    fmask_sel = 32'd0;
    for (int i = 0; i < NFILT; i++) begin
      fid_sel   = fid_sel | ((fsel_q == 3'(i)) ? f_id_rd[i] : 32'd0);
      fmask_sel = fmask_sel | ((fsel_q == 3'(i)) ? f_mask_rd[i] : 32'd0);
    end
    q = 32'd0;
    if (cs) begin
      case (rs)
        REG_HEAD_ID:    q = {head.ext, head.rtr, 1'b0, head.id};
        REG_HEAD_DLC:   q = {28'd0, head.dlc};
        REG_HEAD_DATA0: q = head.data[31:0];
        REG_HEAD_DATA1: q = head.data[63:32];
        REG_CTRL:       q = {rej_q, 3'b000, thresh_q, 6'd0, irqen_q,
                             ovf_q, full_s, empty_s, 5'(level_q)};
        REG_FSEL:       q = {29'd0, fsel_q};
        REG_FID:        q = fid_sel;
        REG_FMASK:      q = fmask_sel;
        default:        q = 32'd0;
      endcase
    end else begin
      q = 32'd0;
    end
  end

  assign irq = (irqen_q[0] & (8'(level_q) >= 8'(thresh_q)) & (thresh_q != 5'd0))
             | (irqen_q[1] & ovf_q);

endmodule
